// File: rtl/deserializer_stream.sv
// deserializer_stream: packs LANE_WIDTH-bit beats into DATA_WIDTH-bit words behind a registered valid/ready output.
//   Ports: i_clk, i_rst (async, active-high), i_wen/i_data (beat in), i_sync (frame restart),
//          i_ready (consumer ready), o_data/o_valid (word out), o_overflow (dropped-word pulse),
//          o_perr (parity error, qualified by o_valid).
//   Optional: define DESER_PARITY_EN to append an even-parity beat to every frame.
module deserializer_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wen,
    input  logic [LANE_WIDTH-1:0] i_data,
    input  logic                  i_sync,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overflow,
    output logic                  o_perr
);
    localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
    localparam int CW = $clog2(BEATS + 1);
`ifdef DESER_PARITY_EN
    localparam int LAST = BEATS;
`else
    localparam int LAST = BEATS - 1;
`endif
    logic [CW-1:0]         cnt_q, cnt_d, k;
    logic [DATA_WIDTH-1:0] asm_q, asm_d, data_q, data_d;
    logic                  valid_q, valid_d, ovf_q, ovf_d, perr_q, perr_d;
    logic                  complete, load;
    always_comb begin
        // a sync beat is treated as beat 0 of a fresh frame
        k = i_sync ? '0 : cnt_q;
        complete = i_wen && (k == CW'(LAST));
        asm_d = asm_q;
        for (int b = 0; b < BEATS; b++)
            if (i_wen && k == CW'(b))
                asm_d[((MSB_FIRST != 0) ? BEATS - 1 - b : b) * LANE_WIDTH +: LANE_WIDTH] = i_data;
        cnt_d = i_wen ? (complete ? '0 : k + CW'(1)) : k;
        load = complete && (!valid_q || i_ready);
        valid_d = load || (valid_q && !i_ready);
        data_d = load ? asm_d : data_q;
        ovf_d = complete && valid_q && !i_ready;
`ifdef DESER_PARITY_EN
        perr_d = load ? ((^asm_d) != i_data[0]) : perr_q;
`else
        perr_d = 1'b0;
`endif
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
        end
    end
    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;
    assign o_perr     = perr_q;
endmodule

// File: tb/tb_deserializer_stream.sv
// tb_deserializer_stream: directed checks on three parameterisations of deserializer_stream.
module tb_deserializer_stream;
`ifdef DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    logic        clk = 1'b0, rst = 1'b1, wen = 1'b0, sync = 1'b0, ready = 1'b1;
    logic [3:0]  dat = '0;
    logic [7:0]  d0;
    logic [15:0] d1, d2, obs_data;
    logic        v0, v1, v2, o0, o1, o2, p0, p1, p2, obs_valid, obs_ovf, obs_perr;
    int          sel = 0, checks = 0, errors = 0;

    always #5 clk = ~clk;

    deserializer_stream u0 (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_data(dat[0]), .i_sync(sync), .i_ready(ready),
        .o_data(d0), .o_valid(v0), .o_overflow(o0), .o_perr(p0)
    );
    deserializer_stream #(.DATA_WIDTH(16), .LANE_WIDTH(4), .MSB_FIRST(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_data(dat), .i_sync(sync), .i_ready(ready),
        .o_data(d1), .o_valid(v1), .o_overflow(o1), .o_perr(p1)
    );
    deserializer_stream #(.DATA_WIDTH(16), .LANE_WIDTH(4), .MSB_FIRST(0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_wen(wen), .i_data(dat), .i_sync(sync), .i_ready(ready),
        .o_data(d2), .o_valid(v2), .o_overflow(o2), .o_perr(p2)
    );

    always_comb begin
        obs_data  = (sel == 0) ? {8'h00, d0} : (sel == 1) ? d1 : d2;
        obs_valid = (sel == 0) ? v0 : (sel == 1) ? v1 : v2;
        obs_ovf   = (sel == 0) ? o0 : (sel == 1) ? o1 : o2;
        obs_perr  = (sel == 0) ? p0 : (sel == 1) ? p1 : p2;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic use_dut(input int s);
        sel = s;
        #1;
    endtask

    task automatic reset_all();
        wen = 1'b0; sync = 1'b0; ready = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle();
        wen = 1'b0; sync = 1'b0;
        @(negedge clk);
    endtask

    task automatic beat(input logic [3:0] d);
        wen = 1'b1; sync = 1'b0; dat = d;
        @(negedge clk);
    endtask

    // Sends one frame to the selected DUT; ready switches to rdy_last on the final beat.
    task automatic frame(input logic [15:0] w, input logic par_ok, input logic rdy_last, input logic pre_v);
        int nb, lw, total;
        logic msb;
        nb = (sel == 0) ? 8 : 4;
        lw = (sel == 0) ? 1 : 4;
        msb = (sel == 1);
        total = nb + PAR;
        for (int i = 0; i < total; i++) begin
            if (i == total - 1) begin
                check("pre_valid", {15'b0, obs_valid}, {15'b0, pre_v});
                ready = rdy_last;
            end
            wen = 1'b1; sync = 1'b0;
            if (i < nb) dat = (lw == 1) ? {3'b0, w[i]} : w[(msb ? nb - 1 - i : i) * 4 +: 4];
            else dat = {3'b0, (^w) ^ ~par_ok};
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            use_dut(s);
            check("rst_data", obs_data, 16'h0);
            check("rst_valid", {15'b0, obs_valid}, 16'h0);
        end
        check("rst_ovf", {15'b0, obs_ovf}, 16'h0);
        check("rst_perr", {15'b0, obs_perr}, 16'h0);
        rst = 1'b0;

        // LSB-first single-bit lanes
        use_dut(0);
        frame(16'h004D, 1'b1, 1'b1, 1'b0);
        check("t1_data", obs_data, 16'h004D);
        check("t1_valid", {15'b0, obs_valid}, 16'h1);
        check("t1_ovf", {15'b0, obs_ovf}, 16'h0);
        idle();
        check("t1_valid_drop", {15'b0, obs_valid}, 16'h0);
        check("t1_data_hold", obs_data, 16'h004D);

        // MSB-first nibble lanes
        reset_all();
        use_dut(1);
        frame(16'hABCD, 1'b1, 1'b1, 1'b0);
        check("t2_data", obs_data, 16'hABCD);
        check("t2_valid", {15'b0, obs_valid}, 16'h1);
        idle();
        check("t2_valid_drop", {15'b0, obs_valid}, 16'h0);

        // overflow under backpressure, sync leaves a pending word alone
        reset_all();
        use_dut(2);
        ready = 1'b0;
        frame(16'h1234, 1'b1, 1'b0, 1'b0);
        check("t3_data1", obs_data, 16'h1234);
        check("t3_valid1", {15'b0, obs_valid}, 16'h1);
        check("t3_ovf0", {15'b0, obs_ovf}, 16'h0);
        frame(16'h5678, 1'b1, 1'b0, 1'b1);
        check("t3_ovf_pulse", {15'b0, obs_ovf}, 16'h1);
        check("t3_data_kept", obs_data, 16'h1234);
        check("t3_valid_kept", {15'b0, obs_valid}, 16'h1);
        idle();
        check("t3_ovf_clear", {15'b0, obs_ovf}, 16'h0);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        check("t3_sync_data", obs_data, 16'h1234);
        check("t3_sync_valid", {15'b0, obs_valid}, 16'h1);
        ready = 1'b1;
        idle();
        check("t3_valid_drop", {15'b0, obs_valid}, 16'h0);
        check("t3_data_hold", obs_data, 16'h1234);

        // back-to-back delivery without a gap
        reset_all();
        use_dut(0);
        ready = 1'b0;
        frame(16'h00A5, 1'b1, 1'b0, 1'b0);
        check("t4_data1", obs_data, 16'h00A5);
        frame(16'h003C, 1'b1, 1'b1, 1'b1);
        check("t4_data2", obs_data, 16'h003C);
        check("t4_valid2", {15'b0, obs_valid}, 16'h1);
        check("t4_ovf", {15'b0, obs_ovf}, 16'h0);
        idle();
        check("t4_valid_drop", {15'b0, obs_valid}, 16'h0);

        // sync with a beat restarts the frame at beat 0
        reset_all();
        use_dut(0);
        repeat (3) beat(4'h1);
        wen = 1'b1; sync = 1'b1; dat = 4'h1;
        @(negedge clk);
        repeat (6) beat(4'h0);
        check("t5_no_word", {15'b0, obs_valid}, 16'h0);
        beat(4'h0);
`ifdef DESER_PARITY_EN
        check("t5_no_word_par", {15'b0, obs_valid}, 16'h0);
        beat(4'h1);
`endif
        check("t5_data", obs_data, 16'h0001);
        check("t5_valid", {15'b0, obs_valid}, 16'h1);
        idle();
        // sync without a beat clears the counter
        beat(4'h1);
        beat(4'h1);
        idle();
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        frame(16'h0080, 1'b1, 1'b1, 1'b0);
        check("t5b_data", obs_data, 16'h0080);
        idle();

        // parity flag, then async reset mid-frame with a word pending
        reset_all();
        use_dut(0);
        frame(16'h0007, 1'b0, 1'b1, 1'b0);
        check("t6_data_bad", obs_data, 16'h0007);
        check("t6_valid_bad", {15'b0, obs_valid}, 16'h1);
        check("t6_perr_bad", {15'b0, obs_perr}, PAR[15:0]);
        idle();
        frame(16'h0007, 1'b1, 1'b1, 1'b0);
        check("t6_data_ok", obs_data, 16'h0007);
        check("t6_perr_ok", {15'b0, obs_perr}, 16'h0);
        ready = 1'b0;
        idle();
        repeat (3) beat(4'h1);
        wen = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_rst_data", obs_data, 16'h0);
        check("t6_rst_valid", {15'b0, obs_valid}, 16'h0);
        check("t6_rst_ovf", {15'b0, obs_ovf}, 16'h0);
        check("t6_rst_perr", {15'b0, obs_perr}, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        frame(16'h005A, 1'b1, 1'b1, 1'b0);
        check("t6_restart_data", obs_data, 16'h005A);
        check("t6_restart_valid", {15'b0, obs_valid}, 16'h1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
